mac_pause_ctrl_rx_mc: RTL and testbench
=======================================

Name: mac_pause_ctrl_rx_mc

Overview:
Parametrised successor to the single-instance PAUSE/PFC receive handler. Decodes MAC control frames (802.3 annex 31B LFC and 31D PFC) for a configurable number of priority classes and maintains per-class pause timers that count down in 512-bit-time quanta. Drives req/ack pause handshakes to the TX scheduler and adds new functions:
- quanta clamping
- optional LFC-to-all-classes fan-out
- countdown-expiry pulses
- saturating per-class XOFF event counters

Sits between the RX MAC control-frame parser and the TX pause/flow-control logic.

Parameters:
PRIO_CNT, 8, number of PFC classes (1..8)
QW, 16, pause quanta timer width (16..24)
QFB, 8, quanta fractional accumulator bits
MCF_PARAMS_SIZE, 18, MCF parameter bytes; must be >= 2+2*PRIO_CNT when PFC_EN, else >= 2 (elaboration $fatal otherwise)
PFC_EN, 1, enables PFC decode and PFC timers
STAT_CNT_W, 16, width of per-class XOFF event counters

Ports:
clk  in  1  clock
rst  in  1  reset
mcf_valid  in  1  single-cycle strobe: control frame fields valid
mcf_opcode  in  16  control opcode
mcf_params  in  MCF_PARAMS_SIZE*8  params; byte n at [8n+:8]
rx_lfc_en  in  1  LFC pause permitted by consumer
rx_lfc_req  out  1  LFC pause request
rx_lfc_ack  in  1  consumer currently paused (LFC)
rx_pfc_en  in  PRIO_CNT  per-class permit
rx_pfc_req  out  PRIO_CNT  per-class pause request
rx_pfc_ack  in  PRIO_CNT  per-class paused
cfg_rx_lfc_opcode  in  16  LFC opcode (nominal 0x0001)
cfg_rx_lfc_en  in  1  LFC decode enable
cfg_rx_pfc_opcode  in  16  PFC opcode (nominal 0x0101)
cfg_rx_pfc_en  in  1  PFC decode enable
cfg_quanta_step  in  10  quanta per clk_en, fixed point QFB fraction bits
cfg_quanta_clk_en  in  1  accumulator advance enable
cfg_quanta_max  in  QW  clamp on loaded quanta; 0 = no clamp
cfg_lfc_to_pfc  in  1  LFC frame also loads every PFC class
stat_clr  in  1  synchronous clear of event counters
stat_rx_lfc_pkt / _xon / _xoff  out  1 each  one-cycle event pulses
stat_rx_lfc_paused  out  1  = rx_lfc_req
stat_rx_lfc_expire  out  1  LFC timer counted down to zero
stat_rx_pfc_pkt  out  1  PFC frame pulse
stat_rx_pfc_xon / _xoff / _expire  out  PRIO_CNT each  per-class pulses
stat_rx_pfc_paused  out  PRIO_CNT  = rx_pfc_req
stat_rx_pfc_xoff_cnt  out  PRIO_CNT*STAT_CNT_W  class k at [k*STAT_CNT_W+:STAT_CNT_W]

Behaviour:
- Reset: all outputs, timers, accumulator and counters are 0.
- Accumulator: when cfg_quanta_clk_en is high, {inc[1:0], cnt[QFB-1:0]} <= cnt + cfg_quanta_step. Otherwise inc <= 0 and cnt holds. The inc value is registered and consumed the following cycle.
- Countdown per timer (LFC and each class):
  - If ack is high, timer <= max(timer - inc, 0), saturating.
  - If ack is low, the timer holds.
- Quanta decode: values are big-endian.
  - LFC quanta = {byte0, byte1}.
  - PFC class enable vector = byte1 bit k.
  - PFC class k quanta = {byte(2+2k), byte(3+2k)}, zero-extended to QW.
- Clamp: when cfg_quanta_max != 0, the loaded value is min(value, cfg_quanta_max).
- LFC match: mcf_valid and opcode == cfg_rx_lfc_opcode and cfg_rx_lfc_en.
  - Loads the LFC timer.
  - Pulses pkt, plus xon if the raw value is 0, else xoff.
  - If cfg_lfc_to_pfc, PFC_EN and cfg_rx_pfc_en are all set, every PFC class loads the same clamped value, pulses its xon/xoff, and increments its counter on xoff. stat_rx_pfc_pkt does not pulse.
- PFC match: taken only if the LFC match fails (LFC has priority when opcodes are equal). Requires PFC_EN, opcode == cfg_rx_pfc_opcode and cfg_rx_pfc_en. Only classes with their enable bit set load and pulse xon/xoff; other classes keep counting down.
- Frame load overrides countdown in the same cycle.
- req <= (timer != 0) && en && cfg_*_en, registered. req therefore lags the timer by 1 cycle, and a frame load is visible on req 2 cycles after mcf_valid.
- Expire pulse: fires for one cycle when a timer transitions nonzero -> 0 through countdown. It does not fire on an XON load.
- Stat pulses are registered, 1 cycle after mcf_valid.
- XOFF counters: increment on each per-class xoff pulse and saturate at all-ones. stat_clr wins over a simultaneous increment.
- Dropping cfg_*_en deasserts req next cycle but does not clear timers; countdown continues while ack is high.
- Reset mid-pause: timers zero and req drops on the cycle after rst.
- PFC_EN=0: PFC outputs are tied to 0 and no PFC state is synthesised.

Test Plan:
- Timer load and request: step=0x100 with clk_en=1, ack follows req, LFC frame with quanta 0x0010. Required: lfc_xoff pulse; req high 2 cycles after mcf_valid; 16 decrements, then expire pulse and req low.
- Per-class load and clamp: PFC frame, enable vector 0x05, class0=0x0100, class2=0xFFFF, cfg_quanta_max=0x0200. Required: class0 timer=0x0100, class2 timer=0x0200, other classes untouched; xoff pulses 0x05; counters for classes 0 and 2 = 1.
- XON load: XON (quanta 0) during an active pause. Required: timer=0, xon pulse, no expire pulse, req low 2 cycles after the frame.
- LFC fan-out: cfg_lfc_to_pfc=1, cfg_rx_pfc_en=1, LFC quanta 0x0003, PRIO_CNT=4. Required: all 4 class timers=3, stat_rx_pfc_xoff=0xF, stat_rx_pfc_pkt stays 0.
- Counter saturation and clear: STAT_CNT_W=2, 5 XOFF frames. Required: counter holds 3. stat_clr coincident with an xoff gives 0.
- Fractional step: step=0x080 (0.5 quanta). Required: timer decrements once per 2 enabled cycles. With ack low, the timer holds.

Source files
------------

// File: rtl/mac_pause_ctrl_rx_mc.sv
// Receive-side PAUSE/PFC handler: decodes MAC control frames and runs per-class pause
// timers in 512-bit-time quanta, driving req/ack pause handshakes toward the TX scheduler.
module mac_pause_ctrl_rx_mc #(
  parameter int PRIO_CNT        = 8,
  parameter int QW              = 16,
  parameter int QFB             = 8,
  parameter int MCF_PARAMS_SIZE = 18,
  parameter int PFC_EN          = 1,
  parameter int STAT_CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mcf_valid,
  input  logic [15:0]                    mcf_opcode,
  input  logic [MCF_PARAMS_SIZE*8-1:0]   mcf_params,
  input  logic                           rx_lfc_en,
  output logic                           rx_lfc_req,
  input  logic                           rx_lfc_ack,
  input  logic [PRIO_CNT-1:0]            rx_pfc_en,
  output logic [PRIO_CNT-1:0]            rx_pfc_req,
  input  logic [PRIO_CNT-1:0]            rx_pfc_ack,
  input  logic [15:0]                    cfg_rx_lfc_opcode,
  input  logic                           cfg_rx_lfc_en,
  input  logic [15:0]                    cfg_rx_pfc_opcode,
  input  logic                           cfg_rx_pfc_en,
  input  logic [9:0]                     cfg_quanta_step,
  input  logic                           cfg_quanta_clk_en,
  input  logic [QW-1:0]                  cfg_quanta_max,
  input  logic                           cfg_lfc_to_pfc,
  input  logic                           stat_clr,
  output logic                           stat_rx_lfc_pkt,
  output logic                           stat_rx_lfc_xon,
  output logic                           stat_rx_lfc_xoff,
  output logic                           stat_rx_lfc_paused,
  output logic                           stat_rx_lfc_expire,
  output logic                           stat_rx_pfc_pkt,
  output logic [PRIO_CNT-1:0]            stat_rx_pfc_xon,
  output logic [PRIO_CNT-1:0]            stat_rx_pfc_xoff,
  output logic [PRIO_CNT-1:0]            stat_rx_pfc_paused,
  output logic [PRIO_CNT-1:0]            stat_rx_pfc_expire,
  output logic [PRIO_CNT*STAT_CNT_W-1:0] stat_rx_pfc_xoff_cnt
);

  localparam int MIN_PARAMS = (PFC_EN != 0) ? (2 + 2 * PRIO_CNT) : 2;
  localparam logic [QW-1:0] Q_ZERO = {QW{1'b0}};

  if (MCF_PARAMS_SIZE < MIN_PARAMS) begin : g_bad_params
    $fatal(1, "MCF_PARAMS_SIZE too small for the configured class count");
  end
  if (PRIO_CNT < 1 || PRIO_CNT > 8) begin : g_bad_prio
    $fatal(1, "PRIO_CNT must be within 1..8");
  end
  if (QW < 16 || QW > 24) begin : g_bad_qw
    $fatal(1, "QW must be within 16..24");
  end

  function automatic logic [QW-1:0] clamp_q(input logic [QW-1:0] v, input logic [QW-1:0] mx);
    if (mx != Q_ZERO && v > mx) begin
      clamp_q = mx;
    end else begin
      clamp_q = v;
    end
  endfunction

  function automatic logic [QW-1:0] count_down(input logic [QW-1:0] t, input logic [1:0] dec);
    if (t > QW'(dec)) begin
      count_down = t - QW'(dec);
    end else begin
      count_down = Q_ZERO;
    end
  endfunction

  // Quanta accumulator: the carry out of the fractional part is the per-cycle decrement.
  logic [QFB-1:0] acc_r;
  logic [1:0]     inc_r;
  logic [QFB+1:0] acc_sum_s;

  assign acc_sum_s = {2'b00, acc_r} + (QFB+2)'(cfg_quanta_step);

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r <= {QFB{1'b0}};
      inc_r <= 2'b00;
    end else if (cfg_quanta_clk_en) begin
      {inc_r, acc_r} <= acc_sum_s;
    end else begin
      inc_r <= 2'b00;
    end
  end

  logic [15:0]   lfc_raw_s;
  logic [QW-1:0] lfc_val_s;
  logic          lfc_match_s;
  logic [QW-1:0] lfc_timer_r;

  assign lfc_raw_s   = {mcf_params[7:0], mcf_params[15:8]};
  assign lfc_val_s   = clamp_q(QW'(lfc_raw_s), cfg_quanta_max);
  assign lfc_match_s = mcf_valid && (mcf_opcode == cfg_rx_lfc_opcode) && cfg_rx_lfc_en;

  // LFC timer, request and event pulses; a frame load takes precedence over countdown.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfc_timer_r        <= Q_ZERO;
      rx_lfc_req         <= 1'b0;
      stat_rx_lfc_pkt    <= 1'b0;
      stat_rx_lfc_xon    <= 1'b0;
      stat_rx_lfc_xoff   <= 1'b0;
      stat_rx_lfc_expire <= 1'b0;
    end else begin
      if (lfc_match_s) begin
        lfc_timer_r <= lfc_val_s;
      end else if (rx_lfc_ack) begin
        lfc_timer_r <= count_down(lfc_timer_r, inc_r);
      end else begin
        lfc_timer_r <= lfc_timer_r;
      end
      rx_lfc_req         <= (lfc_timer_r != Q_ZERO) && rx_lfc_en && cfg_rx_lfc_en;
      stat_rx_lfc_pkt    <= lfc_match_s;
      stat_rx_lfc_xon    <= lfc_match_s && (lfc_raw_s == 16'h0000);
      stat_rx_lfc_xoff   <= lfc_match_s && (lfc_raw_s != 16'h0000);
      stat_rx_lfc_expire <= !lfc_match_s && rx_lfc_ack && (lfc_timer_r != Q_ZERO) &&
                            (lfc_timer_r <= QW'(inc_r));
    end
  end

  assign stat_rx_lfc_paused = rx_lfc_req;

  if (PFC_EN != 0) begin : g_pfc
    logic pfc_match_s;
    logic fan_s;
    logic pkt_r;

    // LFC wins when both opcodes match the same frame.
    assign pfc_match_s = mcf_valid && !lfc_match_s && (mcf_opcode == cfg_rx_pfc_opcode) &&
                         cfg_rx_pfc_en;
    assign fan_s       = lfc_match_s && cfg_lfc_to_pfc && cfg_rx_pfc_en;

    // PFC frame pulse; fan-out loads from an LFC frame do not count as PFC frames.
    always_ff @(posedge clk) begin
      if (rst) begin
        pkt_r <= 1'b0;
      end else begin
        pkt_r <= pfc_match_s;
      end
    end

    assign stat_rx_pfc_pkt = pkt_r;

    for (genvar k = 0; k < PRIO_CNT; k++) begin : g_cls
      logic [15:0]           cls_raw_s;
      logic [15:0]           sel_raw_s;
      logic [QW-1:0]         val_s;
      logic                  load_s;
      logic                  xoff_s;
      logic [QW-1:0]         timer_r;
      logic                  req_r;
      logic                  xon_r;
      logic                  xoff_r;
      logic                  exp_r;
      logic [STAT_CNT_W-1:0] cnt_r;

      assign cls_raw_s = {mcf_params[8*(2+2*k) +: 8], mcf_params[8*(3+2*k) +: 8]};
      assign sel_raw_s = fan_s ? lfc_raw_s : cls_raw_s;
      assign val_s     = clamp_q(QW'(sel_raw_s), cfg_quanta_max);
      assign load_s    = fan_s || (pfc_match_s && mcf_params[8+k]);
      assign xoff_s    = load_s && (sel_raw_s != 16'h0000);

      // Per-class timer, request, pulses and saturating XOFF counter (clear has priority).
      always_ff @(posedge clk) begin
        if (rst) begin
          timer_r <= Q_ZERO;
          req_r   <= 1'b0;
          xon_r   <= 1'b0;
          xoff_r  <= 1'b0;
          exp_r   <= 1'b0;
          cnt_r   <= {STAT_CNT_W{1'b0}};
        end else begin
          if (load_s) begin
            timer_r <= val_s;
          end else if (rx_pfc_ack[k]) begin
            timer_r <= count_down(timer_r, inc_r);
          end else begin
            timer_r <= timer_r;
          end
          req_r  <= (timer_r != Q_ZERO) && rx_pfc_en[k] && cfg_rx_pfc_en;
          xon_r  <= load_s && (sel_raw_s == 16'h0000);
          xoff_r <= xoff_s;
          exp_r  <= !load_s && rx_pfc_ack[k] && (timer_r != Q_ZERO) &&
                    (timer_r <= QW'(inc_r));
          if (stat_clr) begin
            cnt_r <= {STAT_CNT_W{1'b0}};
          end else if (xoff_s && (cnt_r != {STAT_CNT_W{1'b1}})) begin
            cnt_r <= cnt_r + {{(STAT_CNT_W-1){1'b0}}, 1'b1};
          end else begin
            cnt_r <= cnt_r;
          end
        end
      end

      assign rx_pfc_req[k]                                   = req_r;
      assign stat_rx_pfc_paused[k]                           = req_r;
      assign stat_rx_pfc_xon[k]                              = xon_r;
      assign stat_rx_pfc_xoff[k]                             = xoff_r;
      assign stat_rx_pfc_expire[k]                           = exp_r;
      assign stat_rx_pfc_xoff_cnt[k*STAT_CNT_W +: STAT_CNT_W] = cnt_r;
    end
  end else begin : g_no_pfc
    assign stat_rx_pfc_pkt      = 1'b0;
    assign rx_pfc_req           = {PRIO_CNT{1'b0}};
    assign stat_rx_pfc_paused   = {PRIO_CNT{1'b0}};
    assign stat_rx_pfc_xon      = {PRIO_CNT{1'b0}};
    assign stat_rx_pfc_xoff     = {PRIO_CNT{1'b0}};
    assign stat_rx_pfc_expire   = {PRIO_CNT{1'b0}};
    assign stat_rx_pfc_xoff_cnt = {(PRIO_CNT*STAT_CNT_W){1'b0}};
  end

endmodule

// File: tb/tb_mac_pause_ctrl_rx_mc.sv
// Scoreboard bench for mac_pause_ctrl_rx_mc (4 classes, 2-bit counters): expected output
// records (cycle, pulses, requests, counters) are queued by stimulus and checked by a monitor.
module tb_mac_pause_ctrl_rx_mc;

  localparam logic [15:0] LFC_OP = 16'h0001;
  localparam logic [15:0] PFC_OP = 16'h0101;

  logic        clk = 1'b0;
  logic        rst;
  logic        mcf_valid;
  logic [15:0] mcf_opcode;
  logic [79:0] mcf_params;
  logic        rx_lfc_en;
  logic        rx_lfc_req;
  logic        rx_lfc_ack;
  logic [3:0]  rx_pfc_en;
  logic [3:0]  rx_pfc_req;
  logic [3:0]  rx_pfc_ack;
  logic [15:0] cfg_rx_lfc_opcode;
  logic        cfg_rx_lfc_en;
  logic [15:0] cfg_rx_pfc_opcode;
  logic        cfg_rx_pfc_en;
  logic [9:0]  cfg_quanta_step;
  logic        cfg_quanta_clk_en;
  logic [15:0] cfg_quanta_max;
  logic        cfg_lfc_to_pfc;
  logic        stat_clr;
  logic        stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff;
  logic        stat_rx_lfc_paused, stat_rx_lfc_expire, stat_rx_pfc_pkt;
  logic [3:0]  stat_rx_pfc_xon, stat_rx_pfc_xoff, stat_rx_pfc_paused, stat_rx_pfc_expire;
  logic [7:0]  stat_rx_pfc_xoff_cnt;

  logic lfc_follow;
  assign rx_lfc_ack = lfc_follow ? rx_lfc_req : 1'b0;
  assign rx_pfc_ack = rx_pfc_req;

  mac_pause_ctrl_rx_mc #(
    .PRIO_CNT(4), .QW(16), .QFB(8), .MCF_PARAMS_SIZE(10), .PFC_EN(1), .STAT_CNT_W(2)
  ) dut (
    .clk(clk), .rst(rst), .mcf_valid(mcf_valid), .mcf_opcode(mcf_opcode),
    .mcf_params(mcf_params), .rx_lfc_en(rx_lfc_en), .rx_lfc_req(rx_lfc_req),
    .rx_lfc_ack(rx_lfc_ack), .rx_pfc_en(rx_pfc_en), .rx_pfc_req(rx_pfc_req),
    .rx_pfc_ack(rx_pfc_ack), .cfg_rx_lfc_opcode(cfg_rx_lfc_opcode),
    .cfg_rx_lfc_en(cfg_rx_lfc_en), .cfg_rx_pfc_opcode(cfg_rx_pfc_opcode),
    .cfg_rx_pfc_en(cfg_rx_pfc_en), .cfg_quanta_step(cfg_quanta_step),
    .cfg_quanta_clk_en(cfg_quanta_clk_en), .cfg_quanta_max(cfg_quanta_max),
    .cfg_lfc_to_pfc(cfg_lfc_to_pfc), .stat_clr(stat_clr),
    .stat_rx_lfc_pkt(stat_rx_lfc_pkt), .stat_rx_lfc_xon(stat_rx_lfc_xon),
    .stat_rx_lfc_xoff(stat_rx_lfc_xoff), .stat_rx_lfc_paused(stat_rx_lfc_paused),
    .stat_rx_lfc_expire(stat_rx_lfc_expire), .stat_rx_pfc_pkt(stat_rx_pfc_pkt),
    .stat_rx_pfc_xon(stat_rx_pfc_xon), .stat_rx_pfc_xoff(stat_rx_pfc_xoff),
    .stat_rx_pfc_paused(stat_rx_pfc_paused), .stat_rx_pfc_expire(stat_rx_pfc_expire),
    .stat_rx_pfc_xoff_cnt(stat_rx_pfc_xoff_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cy;
    logic [16:0] ev;
    logic [4:0]  req;
    logic [7:0]  cnt;
  } rec_t;

  rec_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // ev = {lfc pkt, xon, xoff, expire, pfc pkt, pfc xon[3:0], pfc xoff[3:0], pfc expire[3:0]}
  function automatic logic [16:0] mk(input logic lp, input logic lxn, input logic lxf,
                                     input logic lex, input logic pp, input logic [3:0] pxn,
                                     input logic [3:0] pxf, input logic [3:0] pex);
    return {lp, lxn, lxf, lex, pp, pxn, pxf, pex};
  endfunction

  function automatic logic [79:0] lfcp(input logic [15:0] q);
    logic [79:0] p;
    p = 80'd0;
    p[7:0]  = q[15:8];
    p[15:8] = q[7:0];
    return p;
  endfunction

  function automatic logic [79:0] pfcp(input logic [7:0] en, input logic [15:0] q0,
                                       input logic [15:0] q1, input logic [15:0] q2,
                                       input logic [15:0] q3);
    logic [79:0] p;
    p = 80'd0;
    p[15:8]  = en;
    p[23:16] = q0[15:8];  p[31:24] = q0[7:0];
    p[39:32] = q1[15:8];  p[47:40] = q1[7:0];
    p[55:48] = q2[15:8];  p[63:56] = q2[7:0];
    p[71:64] = q3[15:8];  p[79:72] = q3[7:0];
    return p;
  endfunction

  task automatic exp_rec(input int cy, input logic [16:0] ev, input logic [4:0] req,
                         input logic [7:0] cnt);
    rec_t r;
    r.cy = cy; r.ev = ev; r.req = req; r.cnt = cnt;
    sb.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] op, input logic [79:0] p, input logic clr);
    mcf_valid = 1'b1; mcf_opcode = op; mcf_params = p; stat_clr = clr;
    tick();
    mcf_valid = 1'b0; mcf_params = 80'd0; stat_clr = 1'b0;
  endtask

  // Monitor: any pulse or any change of request/counter outputs consumes one record.
  initial begin : monitor
    logic [16:0] cur_ev;
    logic [4:0]  cur_req, cur_paused, prev_req;
    logic [7:0]  cur_cnt, prev_cnt;
    rec_t e;
    prev_req = 5'd0;
    prev_cnt = 8'd0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        cur_ev     = {stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff, stat_rx_lfc_expire,
                      stat_rx_pfc_pkt, stat_rx_pfc_xon, stat_rx_pfc_xoff, stat_rx_pfc_expire};
        cur_req    = {rx_lfc_req, rx_pfc_req};
        cur_paused = {stat_rx_lfc_paused, stat_rx_pfc_paused};
        cur_cnt    = stat_rx_pfc_xoff_cnt;
        if (cur_ev != 17'd0 || cur_req != prev_req || cur_cnt != prev_cnt) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output cyc=%0d ev=%h req=%b cnt=%h", cyc, cur_ev,
                     cur_req, cur_cnt);
          end else begin
            e = sb.pop_front();
            if (e.cy != cyc || e.ev !== cur_ev || e.req !== cur_req ||
                e.req !== cur_paused || e.cnt !== cur_cnt) begin
              n_fail++;
              $display("FAIL sb_record got cyc=%0d ev=%h req=%b paused=%b cnt=%h want cyc=%0d ev=%h req=%b cnt=%h",
                       cyc, cur_ev, cur_req, cur_paused, cur_cnt, e.cy, e.ev, e.req, e.cnt);
            end
          end
        end
        prev_req = cur_req;
        prev_cnt = cur_cnt;
      end
    end
  end

  initial begin : stimulus
    int c;
    int c2;
    int s;
    int nsat;
    rst = 1'b1; mcf_valid = 1'b0; mcf_opcode = 16'h0000; mcf_params = 80'd0;
    rx_lfc_en = 1'b1; rx_pfc_en = 4'hF; lfc_follow = 1'b1;
    cfg_rx_lfc_opcode = LFC_OP; cfg_rx_lfc_en = 1'b1;
    cfg_rx_pfc_opcode = PFC_OP; cfg_rx_pfc_en = 1'b0;
    cfg_quanta_step = 10'h100; cfg_quanta_clk_en = 1'b1; cfg_quanta_max = 16'h0000;
    cfg_lfc_to_pfc = 1'b0; stat_clr = 1'b0;
    idle(3);

    n_checks++;
    if ({rx_lfc_req, rx_pfc_req, stat_rx_lfc_pkt, stat_rx_lfc_xon, stat_rx_lfc_xoff,
         stat_rx_lfc_paused, stat_rx_lfc_expire, stat_rx_pfc_pkt, stat_rx_pfc_xon,
         stat_rx_pfc_xoff, stat_rx_pfc_paused, stat_rx_pfc_expire,
         stat_rx_pfc_xoff_cnt} !== 38'd0) begin
      n_fail++;
      $display("FAIL reset_state outputs not all zero: req=%b cnt=%h", {rx_lfc_req, rx_pfc_req},
               stat_rx_pfc_xoff_cnt);
    end
    rst = 1'b0;
    tick();
    mon_en = 1'b1;
    idle(2);

    // LFC 16 quanta, one quantum per cycle
    c = cyc;
    exp_rec(c+1,  mk(1,0,1,0,0,4'h0,4'h0,4'h0), 5'b00000, 8'h00);
    exp_rec(c+2,  17'd0,                        5'b10000, 8'h00);
    exp_rec(c+18, mk(0,0,0,1,0,4'h0,4'h0,4'h0), 5'b10000, 8'h00);
    exp_rec(c+19, 17'd0,                        5'b00000, 8'h00);
    send(LFC_OP, lfcp(16'h0010), 1'b0);
    idle(25);

    // PFC classes 0 and 2, class 2 clamped to 0x200; classes 1/3 carry ignored values
    cfg_rx_pfc_en = 1'b1; cfg_quanta_max = 16'h0200;
    tick();
    c = cyc;
    exp_rec(c+1,   mk(0,0,0,0,1,4'h0,4'h5,4'h0), 5'b00000, 8'h11);
    exp_rec(c+2,   17'd0,                        5'b00101, 8'h11);
    exp_rec(c+258, mk(0,0,0,0,0,4'h0,4'h0,4'h1), 5'b00101, 8'h11);
    exp_rec(c+259, 17'd0,                        5'b00100, 8'h11);
    exp_rec(c+514, mk(0,0,0,0,0,4'h0,4'h0,4'h4), 5'b00100, 8'h11);
    exp_rec(c+515, 17'd0,                        5'b00000, 8'h11);
    send(PFC_OP, pfcp(8'h05, 16'h0100, 16'h1234, 16'hFFFF, 16'h5678), 1'b0);
    idle(520);

    // XON while paused
    cfg_quanta_max = 16'h0000;
    c = cyc;
    exp_rec(c+1, mk(1,0,1,0,0,4'h0,4'h0,4'h0), 5'b00000, 8'h11);
    exp_rec(c+2, 17'd0,                        5'b10000, 8'h11);
    send(LFC_OP, lfcp(16'h0100), 1'b0);
    idle(9);
    c2 = cyc;
    exp_rec(c2+1, mk(1,1,0,0,0,4'h0,4'h0,4'h0), 5'b10000, 8'h11);
    exp_rec(c2+2, 17'd0,                        5'b00000, 8'h11);
    send(LFC_OP, lfcp(16'h0000), 1'b0);
    idle(10);

    // Dropping the decode enable drops req but keeps the timer (28 quanta left)
    c = cyc;
    exp_rec(c+1,  mk(1,0,1,0,0,4'h0,4'h0,4'h0), 5'b00000, 8'h11);
    exp_rec(c+2,  17'd0,                        5'b10000, 8'h11);
    exp_rec(c+6,  17'd0,                        5'b00000, 8'h11);
    exp_rec(c+11, 17'd0,                        5'b10000, 8'h11);
    exp_rec(c+39, mk(0,0,0,1,0,4'h0,4'h0,4'h0), 5'b10000, 8'h11);
    exp_rec(c+40, 17'd0,                        5'b00000, 8'h11);
    send(LFC_OP, lfcp(16'h0020), 1'b0);
    idle(4);
    cfg_rx_lfc_en = 1'b0;
    idle(5);
    cfg_rx_lfc_en = 1'b1;
    idle(35);

    // LFC fan-out to all four classes
    cfg_lfc_to_pfc = 1'b1;
    c = cyc;
    exp_rec(c+1, mk(1,0,1,0,0,4'h0,4'hF,4'h0), 5'b00000, 8'h66);
    exp_rec(c+2, 17'd0,                        5'b11111, 8'h66);
    exp_rec(c+5, mk(0,0,0,1,0,4'h0,4'h0,4'hF), 5'b11111, 8'h66);
    exp_rec(c+6, 17'd0,                        5'b00000, 8'h66);
    send(LFC_OP, lfcp(16'h0003), 1'b0);
    idle(8);
    cfg_lfc_to_pfc = 1'b0;

    // Counter clear, saturation at 3, clear winning over a coincident xoff
    s = cyc;
    exp_rec(s+1, 17'd0, 5'b00000, 8'h00);
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    idle(2);
    for (int i = 0; i < 6; i++) begin
      nsat = (i == 5) ? 0 : ((i + 1 > 3) ? 3 : i + 1);
      c = cyc;
      exp_rec(c+1, mk(0,0,0,0,1,4'h0,4'h2,4'h0), 5'b00000, 8'(nsat << 2));
      exp_rec(c+2, 17'd0,                        5'b00010, 8'(nsat << 2));
      exp_rec(c+3, mk(0,0,0,0,0,4'h0,4'h0,4'h2), 5'b00010, 8'(nsat << 2));
      exp_rec(c+4, 17'd0,                        5'b00000, 8'(nsat << 2));
      send(PFC_OP, pfcp(8'h02, 16'hAAAA, 16'h0001, 16'hBBBB, 16'hCCCC), (i == 5));
      idle(5);
    end

    // Half-quantum step: one decrement per two enabled cycles
    cfg_quanta_step = 10'h080;
    s = cyc;
    idle(2);
    c = cyc;
    exp_rec(c+1,  mk(1,0,1,0,0,4'h0,4'h0,4'h0), 5'b00000, 8'h00);
    exp_rec(c+2,  17'd0,                        5'b10000, 8'h00);
    exp_rec(c+9,  mk(0,0,0,1,0,4'h0,4'h0,4'h0), 5'b10000, 8'h00);
    exp_rec(c+10, 17'd0,                        5'b00000, 8'h00);
    send(LFC_OP, lfcp(16'h0004), 1'b0);
    idle(12);
    lfc_follow = 1'b0;
    idle(s + 20 - cyc);
    c2 = cyc;
    exp_rec(c2+1,  mk(1,0,1,0,0,4'h0,4'h0,4'h0), 5'b00000, 8'h00);
    exp_rec(c2+2,  17'd0,                        5'b10000, 8'h00);
    exp_rec(c2+15, mk(0,0,0,1,0,4'h0,4'h0,4'h0), 5'b10000, 8'h00);
    exp_rec(c2+16, 17'd0,                        5'b00000, 8'h00);
    send(LFC_OP, lfcp(16'h0002), 1'b0);
    idle(11);
    lfc_follow = 1'b1;
    idle(8);

    // Reset in the middle of a pause
    c = cyc;
    exp_rec(c+1, mk(1,0,1,0,0,4'h0,4'h0,4'h0), 5'b00000, 8'h00);
    exp_rec(c+2, 17'd0,                        5'b10000, 8'h00);
    send(LFC_OP, lfcp(16'h0100), 1'b0);
    idle(3);
    c = cyc;
    exp_rec(c+1, 17'd0, 5'b00000, 8'h00);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(10);

    for (int i = 0; i < 50 && sb.size() != 0; i++) tick();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain pending=%0d want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
